// File: rtl/bll_pkg.sv
// rtl/bll_pkg.sv - shared state encoding and nibble width for the serial subtractor
package bll_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} bll_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/bll_serial_subtractor_if.sv
// rtl/bll_serial_subtractor_if.sv - operand/result handshake bundle; zero/neg/ovf exist only with BLL_FLAGS_EN
interface bll_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef BLL_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef BLL_FLAGS_EN
    input  zero, neg, ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef BLL_FLAGS_EN
    output zero, neg, ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/bll.sv
// rtl/bll.sv - 4-bit borrow-lookahead slice, every borrow a flat sum of products
module bll
  import bll_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] borrow
);
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;

  // generate when a<b bitwise, propagate when the bits are equal
  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign borrow[0] = g[0] | (p[0] & bin);
  assign borrow[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign borrow[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & bin);
  assign borrow[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d = a ^ b ^ {borrow[2:0], bin};

endmodule

// File: rtl/bll_serial_subtractor.sv
// rtl/bll_serial_subtractor.sv - nibble-serial a-b-bin with registered inter-nibble borrow; BLL_FLAGS_EN adds zero/neg/ovf
module bll_serial_subtractor
  import bll_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  bll_serial_subtractor_if.slave bus
);
  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  bll_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    diff_q;
  logic                brw;
  logic                bout_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] d_nib;
  logic [NIBBLE_W-1:0] borrow_nib;
  logic [WIDTH-1:0]    diff_nx;

  // one shared slice, operand nibbles selected by the step counter
  always_comb begin
    a_nib   = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    b_nib   = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    diff_nx = diff_q;
    diff_nx[int'(cnt)*NIBBLE_W +: NIBBLE_W] = d_nib;
  end

  bll u_bll (
    .a      (a_nib),
    .b      (b_nib),
    .bin    (brw),
    .d      (d_nib),
    .borrow (borrow_nib)
  );

`ifdef BLL_FLAGS_EN
  logic zero_q;
  logic neg_q;
  logic ovf_q;

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      brw         <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BLL_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            brw        <= bus.bin;
            diff_q     <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          diff_q <= diff_nx;
          brw    <= borrow_nib[NIBBLE_W-1];
          if (cnt == CNT_W'(NIB - 1)) begin
            bout_q      <= borrow_nib[NIBBLE_W-1];
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef BLL_FLAGS_EN
            zero_q      <= (diff_nx == '0);
            neg_q       <= diff_nx[WIDTH-1];
            ovf_q       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_nx[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_bll_serial_subtractor.sv
// tb/tb_bll_serial_subtractor.sv - vector table, corner sequences and random scoreboard run for the serial subtractor
module tb_bll_serial_subtractor;
  import bll_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[10];

  bll_serial_subtractor_if #(.WIDTH(16)) bus ();

  bll_serial_subtractor #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] r;
    exp_t e;
    r      = {1'b0, a} - {1'b0, b} - 17'(bin);
    e.diff = r[15:0];
    e.bout = r[16];
    e.zero = (r[15:0] == 16'h0);
    e.neg  = r[15];
    e.ovf  = (a[15] ^ b[15]) & (r[15] ^ a[15]);
    sb.push_back(e);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("diff", 32'(bus.diff), 32'(e.diff));
    chk("bout", 32'(bus.bout), 32'(e.bout));
`ifdef BLL_FLAGS_EN
    chk("zero", 32'(bus.zero), 32'(e.zero));
    chk("neg",  32'(bus.neg),  32'(e.neg));
    chk("ovf",  32'(bus.ovf),  32'(e.ovf));
`endif
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [15:0] held_diff;
    logic        held_bout;
    logic        seen_valid;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_diff",      32'(bus.diff),      32'd0);
    chk("reset_bout",      32'(bus.bout),      32'd0);
`ifdef BLL_FLAGS_EN
    chk("reset_flags", 32'({bus.zero, bus.neg, bus.ovf}), 32'd0);
`endif

    // table vectors: hand-derived expectations, latency checked on each
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vecs[i].diff, vecs[i].bout, vecs[i].zero, vecs[i].neg, vecs[i].ovf});
      accept(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_out(cyc);
      chk("latency", 32'(cyc), 32'd4);
      check_pop();
      release_out();
    end

    // backpressure with ignored in_valid pulses
    push_model(16'h8000, 16'h0001, 1'b0);
    accept(16'h8000, 16'h0001, 1'b0);
    wait_out(cyc);
    held_diff = bus.diff;
    held_bout = bus.bout;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.a        = 16'(k * 16'h1111);
      bus.b        = 16'h0F0F;
      @(negedge clk);
      chk("bp_diff_stable", 32'(bus.diff),      32'(held_diff));
      chk("bp_bout_stable", 32'(bus.bout),      32'(held_bout));
      chk("bp_in_ready",    32'(bus.in_ready),  32'd0);
      chk("bp_out_valid",   32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    check_pop();
    release_out();
    chk("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);

    // reset while cnt==2
    accept(16'hABCD, 16'h1234, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff",      32'(bus.diff),      32'd0);
    chk("rst_bout",      32'(bus.bout),      32'd0);
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("rst_no_result", 32'(seen_valid), 32'd0);

    // random back-to-back run against the arithmetic model
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      push_model(ra, rb, rbin);
      accept(ra, rb, rbin);
      wait_out(cyc);
      check_pop();
      release_out();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
